kan_train_sequencer: RTL and testbench
======================================

Name: kan_train_sequencer

Overview:
- Controller that sequences the 4-layer integer KAN datapath through training and validation, one step per clock.
- Training runs N_EPOCHS passes over the training set, each record as 14 steps: forward steps 1-8, then backward/update steps 9-14.
- Validation runs 8 forward steps per record over the validation set and accumulates absolute error.
- Drives record/epoch addressing and step strobes to the datapath, and reports the final validation error and progress on LED.

Parameters:
- N_T_RECORDS, 8192, training records per epoch.
- N_V_RECORDS, 2048, validation records.
- N_EPOCHS, 32, training epochs.
- N_FWD_STEPS, 8, forward steps per record.
- N_BWD_STEPS, 6, backward/update steps per record.
- N_ERR_SHIFT, 11, right shift applied to the accumulated validation error.
- N_ACC_W, 48, error accumulator width.

Ports:
- CLK100MHZ  in  1  system clock.
- CPU_RESETN  in  1  asynchronous active-low reset.
- start_i  in  1  one-cycle request to begin the full train+validate run.
- stall_i  in  1  datapath not ready; freezes issue.
- step_o  out  4  step being issued: 1-14; 0 when idle.
- step_valid_o  out  1  step_o is issued this cycle.
- train_o  out  1  1 = training phase, 0 = validation phase.
- record_o  out  13  current record index.
- epoch_o  out  5  current epoch index.
- pred_valid_i  in  1  datapath strobe: pred_i/target_i hold a validation result.
- pred_i  in  32  signed model output (models3[0]).
- target_i  in  32  signed target for that record.
- busy_o  out  1  run in progress.
- done_o  out  1  one-cycle pulse when error_o becomes final.
- error_o  out  32  final validation error; holds until the next start.
- epoch_done_o  out  1  one-cycle pulse after the last step of each epoch.
- LED  out  16  progress or result display.

Behaviour:
- Reset (async, CPU_RESETN=0): every register and output is 0 and the state is IDLE. Reset mid-run aborts immediately; no done_o is produced.
- States:
  - IDLE: start_i=1 -> TRAIN; record=0, epoch=0, step=1, acc=0, vcount=0.
  - TRAIN: issue steps 1..14 in order.
  - VAL: issue steps 1..8 in order.
  - DRAIN: wait for the outstanding validation results.
  - FINISH: one cycle, then back to IDLE.
- Issue rule: step_valid_o = (state is TRAIN or VAL) & !stall_i.
  - While stalled, step_o, record_o and epoch_o hold and nothing advances.
  - Each unstalled cycle advances exactly one step.
- TRAIN wrap (step 14 issued):
  - step <- 1 and record++.
  - At record N_T_RECORDS-1: record <- 0, epoch_done_o pulses next cycle, epoch++.
  - At epoch N_EPOCHS-1: go to VAL with record=0, step=1, train_o=0.
- VAL wrap (step 8 issued):
  - step <- 1 and record++.
  - At record N_V_RECORDS-1 -> DRAIN; step_o goes to 0 and step_valid_o to 0.
- Error accumulation:
  - On each pred_valid_i while in VAL or DRAIN: acc += |target_i - pred_i|, vcount++.
  - The difference is computed at 33 bits signed, so there is no overflow at the ±2^31 extremes.
  - pred_valid_i in IDLE or TRAIN is ignored.
- DRAIN: exits when vcount == N_V_RECORDS, counting a strobe that arrives in the same cycle.
  - error_o <- acc >>> N_ERR_SHIFT, truncated to 32 bits.
  - done_o pulses in the FINISH cycle, then IDLE.
- Latency with no stall:
  - Training: 14·N_T_RECORDS·N_EPOCHS cycles (3,670,016 at defaults).
  - Validation issue: 8·N_V_RECORDS cycles.
  - Plus drain time, plus 1 cycle for FINISH.
- start_i while busy_o=1 is ignored. start_i in the FINISH cycle is also ignored; a new run starts only from IDLE.
- busy_o = 1 in TRAIN, VAL and DRAIN.
- LED:
  - When busy: {epoch_o[4:0], train_o, record_o[12:3]}.
  - Otherwise: error_o[15:0].
- stall_i and pred_valid_i in the same cycle: the accumulation still happens; only issue is frozen.

Test Plan:
- Small run: N_T_RECORDS=4, N_V_RECORDS=2, N_EPOCHS=2, no stall, start pulse -> 112 training steps 1..14 issued, records 0..3 per epoch, epoch_done_o pulses twice, then 16 validation steps; busy_o drops after drain.
- Validation error: same config, pred_valid_i pairs (pred=100, target=-2148) and (pred=-5, target=2043), N_ERR_SHIFT=11 -> acc=4296, error_o=2, done_o pulses once.
- Stall: stall_i held 3 cycles on TRAIN step 5 of record 1 -> step_o=5 and record_o=1 hold, step_valid_o=0 for 3 cycles, then step 6 issues; total run grows by exactly 3 cycles.
- Extremes: pred=0x7FFFFFFF, target=0x80000000 -> abs diff 0xFFFFFFFF accumulated, no sign wrap.
- Reset mid-run: CPU_RESETN low during VAL step 3 -> all outputs 0 asynchronously, no done_o; a fresh start runs the full sequence correctly.
- Ignored inputs: start_i during TRAIN and pred_valid_i during TRAIN -> no restart and no accumulation; acc unchanged at validation start.

Source files
------------

// File: rtl/kan_train_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : kan_train_sequencer_if
// Brief    : Step-issue / prediction-return bundle between sequencer and KAN datapath.
// Revision : 1.0
// ============================================================================
interface kan_train_sequencer_if;
    logic [3:0]  step_o;
    logic        step_valid_o;
    logic        train_o;
    logic [12:0] record_o;
    logic [4:0]  epoch_o;
    logic        stall_i;
    logic        pred_valid_i;
    logic [31:0] pred_i;
    logic [31:0] target_i;

    modport master (
        output step_o, step_valid_o, train_o, record_o, epoch_o,
        input  stall_i, pred_valid_i, pred_i, target_i
    );

    modport slave (
        input  step_o, step_valid_o, train_o, record_o, epoch_o,
        output stall_i, pred_valid_i, pred_i, target_i
    );
endinterface
`default_nettype wire

// File: rtl/kan_train_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : kan_train_sequencer
// Brief    : Sequences the KAN datapath through training epochs and a
//            validation pass, accumulating absolute validation error.
// Revision : 1.0
// ============================================================================
module kan_train_sequencer #(
    parameter int N_T_RECORDS = 8192,
    parameter int N_V_RECORDS = 2048,
    parameter int N_EPOCHS    = 32,
    parameter int N_FWD_STEPS = 8,
    parameter int N_BWD_STEPS = 6,
    parameter int N_ERR_SHIFT = 11,
    parameter int N_ACC_W     = 48
) (
    input  logic                         CLK100MHZ,
    input  logic                         CPU_RESETN,
    input  logic                         start_i,
    kan_train_sequencer_if.master        dp,
    output logic                         busy_o,
    output logic                         done_o,
    output logic [31:0]                  error_o,
    output logic                         epoch_done_o,
    output logic [15:0]                  LED
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_TRAIN  = 3'd1,
        ST_VAL    = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

    localparam int          c_VCNT_W     = $clog2(N_V_RECORDS + 1);
    localparam logic [3:0]  c_TRAIN_LAST = 4'(N_FWD_STEPS + N_BWD_STEPS);
    localparam logic [3:0]  c_VAL_LAST   = 4'(N_FWD_STEPS);
    localparam logic [12:0] c_T_REC_LAST = 13'(N_T_RECORDS - 1);
    localparam logic [12:0] c_V_REC_LAST = 13'(N_V_RECORDS - 1);
    localparam logic [4:0]  c_EPOCH_LAST = 5'(N_EPOCHS - 1);
    localparam logic [c_VCNT_W-1:0] c_V_TOTAL = c_VCNT_W'(N_V_RECORDS);

    state_t                 state_q;
    logic [3:0]             step_q;
    logic                   train_q;
    logic [12:0]            record_q;
    logic [4:0]             epoch_q;
    logic [N_ACC_W-1:0]     acc_q, acc_d;
    logic [c_VCNT_W-1:0]    vcount_q, vcount_d;
    logic [31:0]            error_q;
    logic                   done_q;
    logic                   epoch_done_q;

    logic signed [32:0]     w_diff;
    logic [32:0]            w_absdiff;
    logic                   w_accept;
    logic                   w_issue;

    // 33-bit signed difference keeps |target - pred| exact at the 32-bit extremes
    assign w_diff    = $signed({dp.target_i[31], dp.target_i}) - $signed({dp.pred_i[31], dp.pred_i});
    assign w_absdiff = w_diff[32] ? 33'(-w_diff) : 33'(w_diff);
    assign w_accept  = dp.pred_valid_i && (state_q == ST_VAL || state_q == ST_DRAIN);
    assign w_issue   = (state_q == ST_TRAIN || state_q == ST_VAL) && !dp.stall_i;

    always_comb begin
        acc_d    = acc_q;
        vcount_d = vcount_q;
        if (w_accept) begin
            acc_d    = acc_q + N_ACC_W'(w_absdiff);
            vcount_d = vcount_q + c_VCNT_W'(1);
        end
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state_q      <= ST_IDLE;
            step_q       <= '0;
            train_q      <= 1'b0;
            record_q     <= '0;
            epoch_q      <= '0;
            acc_q        <= '0;
            vcount_q     <= '0;
            error_q      <= '0;
            done_q       <= 1'b0;
            epoch_done_q <= 1'b0;
        end else begin
            done_q       <= 1'b0;
            epoch_done_q <= 1'b0;
            acc_q        <= acc_d;
            vcount_q     <= vcount_d;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_q  <= ST_TRAIN;
                        train_q  <= 1'b1;
                        step_q   <= 4'd1;
                        record_q <= '0;
                        epoch_q  <= '0;
                        acc_q    <= '0;
                        vcount_q <= '0;
                        error_q  <= '0;
                    end
                end
                ST_TRAIN: begin
                    if (w_issue) begin
                        if (step_q == c_TRAIN_LAST) begin
                            step_q <= 4'd1;
                            if (record_q == c_T_REC_LAST) begin
                                record_q     <= '0;
                                epoch_done_q <= 1'b1;
                                epoch_q      <= epoch_q + 5'd1;
                                if (epoch_q == c_EPOCH_LAST) begin
                                    state_q <= ST_VAL;
                                    train_q <= 1'b0;
                                end
                            end else begin
                                record_q <= record_q + 13'd1;
                            end
                        end else begin
                            step_q <= step_q + 4'd1;
                        end
                    end
                end
                ST_VAL: begin
                    if (w_issue) begin
                        if (step_q == c_VAL_LAST) begin
                            if (record_q == c_V_REC_LAST) begin
                                state_q  <= ST_DRAIN;
                                step_q   <= '0;
                                record_q <= '0;
                            end else begin
                                step_q   <= 4'd1;
                                record_q <= record_q + 13'd1;
                            end
                        end else begin
                            step_q <= step_q + 4'd1;
                        end
                    end
                end
                ST_DRAIN: begin
                    // vcount_d includes a strobe landing in this very cycle
                    if (vcount_d == c_V_TOTAL) begin
                        state_q <= ST_FINISH;
                        error_q <= 32'(acc_d >> N_ERR_SHIFT);
                        done_q  <= 1'b1;
                    end
                end
                ST_FINISH: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign dp.step_o       = step_q;
    assign dp.step_valid_o = w_issue;
    assign dp.train_o      = train_q;
    assign dp.record_o     = record_q;
    assign dp.epoch_o      = epoch_q;

    assign busy_o       = (state_q == ST_TRAIN) || (state_q == ST_VAL) || (state_q == ST_DRAIN);
    assign done_o       = done_q;
    assign error_o      = error_q;
    assign epoch_done_o = epoch_done_q;
    assign LED          = busy_o ? {epoch_q, train_q, record_q[12:3]} : error_q[15:0];

endmodule
`default_nettype wire

// File: tb/tb_kan_train_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_kan_train_sequencer
// Brief    : Directed bench for kan_train_sequencer on a reduced 4/2/2 configuration.
// Revision : 1.0
// ============================================================================
module tb_kan_train_sequencer;

    localparam int NT = 4;
    localparam int NV = 2;
    localparam int NE = 2;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, epoch_done;
    logic [31:0] err;
    logic [15:0] led;
    int tests_run    = 0;
    int tests_failed = 0;

    kan_train_sequencer_if dp_if();

    kan_train_sequencer #(
        .N_T_RECORDS(NT),
        .N_V_RECORDS(NV),
        .N_EPOCHS   (NE)
    ) dut (
        .CLK100MHZ   (clk),
        .CPU_RESETN  (rst_n),
        .start_i     (start),
        .dp          (dp_if.master),
        .busy_o      (busy),
        .done_o      (done),
        .error_o     (err),
        .epoch_done_o(epoch_done),
        .LED         (led)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Full start-to-idle run with per-cycle expectations; optional stall/spurious inputs
    task automatic run_sequence(input int st_r, input int st_s, input int st_n,
                                input bit val_stall, input bit spurious,
                                input logic [31:0] pa, input logic [31:0] ta,
                                input logic [31:0] pb, input logic [31:0] tb_v,
                                input logic [31:0] exp_err);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int e = 0; e < NE; e++) begin
            for (int r = 0; r < NT; r++) begin
                for (int s = 1; s <= 14; s++) begin
                    if (e == 0 && r == st_r && s == st_s) begin
                        for (int k = 0; k < st_n; k++) begin
                            dp_if.stall_i = 1'b1;
                            @(negedge clk);
                            tests_run++;
                            if (dp_if.step_valid_o !== 1'b0 || dp_if.step_o !== 4'(s) || dp_if.record_o !== 13'(r)) begin
                                tests_failed++;
                                $display("FAIL train_stall_hold: valid=%0b step=%0d record=%0d, expected 0/%0d/%0d",
                                         dp_if.step_valid_o, dp_if.step_o, dp_if.record_o, s, r);
                            end
                            @(posedge clk); #1;
                        end
                        dp_if.stall_i = 1'b0;
                    end
                    if (spurious && e == 0 && r == 1 && s == 3) begin
                        start              = 1'b1;
                        dp_if.pred_valid_i = 1'b1;
                        dp_if.pred_i       = 32'd0;
                        dp_if.target_i     = 32'd100000;
                    end
                    @(negedge clk);
                    tests_run++;
                    if (dp_if.step_o !== 4'(s) || dp_if.record_o !== 13'(r) || dp_if.epoch_o !== 5'(e) ||
                        dp_if.train_o !== 1'b1 || dp_if.step_valid_o !== 1'b1 || busy !== 1'b1 ||
                        led !== {5'(e), 1'b1, 10'(r >> 3)} || epoch_done !== (s == 1 && r == 0 && e > 0)) begin
                        tests_failed++;
                        $display("FAIL train_step: step=%0d rec=%0d ep=%0d train=%0b valid=%0b busy=%0b led=%h edone=%0b, expected step=%0d rec=%0d ep=%0d",
                                 dp_if.step_o, dp_if.record_o, dp_if.epoch_o, dp_if.train_o, dp_if.step_valid_o,
                                 busy, led, epoch_done, s, r, e);
                    end
                    @(posedge clk); #1;
                    start              = 1'b0;
                    dp_if.pred_valid_i = 1'b0;
                end
            end
        end
        for (int r = 0; r < NV; r++) begin
            for (int s = 1; s <= 8; s++) begin
                if (r == 0 && s == 8) begin
                    dp_if.pred_valid_i = 1'b1;
                    dp_if.pred_i       = pa;
                    dp_if.target_i     = ta;
                    if (val_stall) begin
                        dp_if.stall_i = 1'b1;
                        @(negedge clk);
                        tests_run++;
                        if (dp_if.step_valid_o !== 1'b0 || dp_if.step_o !== 4'd8 || dp_if.record_o !== 13'd0) begin
                            tests_failed++;
                            $display("FAIL val_stall_hold: valid=%0b step=%0d record=%0d, expected 0/8/0",
                                     dp_if.step_valid_o, dp_if.step_o, dp_if.record_o);
                        end
                        @(posedge clk); #1;
                        dp_if.stall_i      = 1'b0;
                        dp_if.pred_valid_i = 1'b0;
                    end
                end
                @(negedge clk);
                tests_run++;
                if (dp_if.step_o !== 4'(s) || dp_if.record_o !== 13'(r) || dp_if.train_o !== 1'b0 ||
                    dp_if.step_valid_o !== 1'b1 || busy !== 1'b1 || epoch_done !== (r == 0 && s == 1)) begin
                    tests_failed++;
                    $display("FAIL val_step: step=%0d rec=%0d train=%0b valid=%0b busy=%0b edone=%0b, expected step=%0d rec=%0d",
                             dp_if.step_o, dp_if.record_o, dp_if.train_o, dp_if.step_valid_o, busy, epoch_done, s, r);
                end
                @(posedge clk); #1;
                dp_if.pred_valid_i = 1'b0;
            end
        end
        // second result lands in the first drain cycle
        dp_if.pred_valid_i = 1'b1;
        dp_if.pred_i       = pb;
        dp_if.target_i     = tb_v;
        @(negedge clk);
        tests_run++;
        if (dp_if.step_o !== 4'd0 || dp_if.step_valid_o !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL drain: step=%0d valid=%0b busy=%0b done=%0b, expected 0/0/1/0",
                     dp_if.step_o, dp_if.step_valid_o, busy, done);
        end
        @(posedge clk); #1;
        dp_if.pred_valid_i = 1'b0;
        if (spurious) start = 1'b1;
        @(negedge clk);
        tests_run++;
        if (done !== 1'b1 || busy !== 1'b0 || err !== exp_err || dp_if.step_valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL finish: done=%0b busy=%0b error=%h valid=%0b, expected 1/0/%h/0",
                     done, busy, err, dp_if.step_valid_o, exp_err);
        end
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        tests_run++;
        if (done !== 1'b0 || busy !== 1'b0 || err !== exp_err || led !== exp_err[15:0] || dp_if.step_o !== 4'd0) begin
            tests_failed++;
            $display("FAIL idle_after: done=%0b busy=%0b error=%h led=%h step=%0d, expected 0/0/%h/%h/0",
                     done, busy, err, led, dp_if.step_o, exp_err, exp_err[15:0]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #12;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || err !== 32'd0 || led !== 16'd0 || epoch_done !== 1'b0 ||
            dp_if.step_o !== 4'd0 || dp_if.step_valid_o !== 1'b0 || dp_if.record_o !== 13'd0 ||
            dp_if.epoch_o !== 5'd0 || dp_if.train_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: busy=%0b done=%0b err=%h led=%h step=%0d valid=%0b, expected all zero",
                     busy, done, err, led, dp_if.step_o, dp_if.step_valid_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if (busy !== 1'b0 || dp_if.step_valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_no_start: busy=%0b valid=%0b, expected 0/0", busy, dp_if.step_valid_o);
        end
    endtask

    task automatic test_small_run();
        run_sequence(-1, 0, 0, 1'b0, 1'b0, 32'd100, -32'sd2148, -32'sd5, 32'd2043, 32'd2);
    endtask

    task automatic test_stall();
        run_sequence(1, 5, 3, 1'b1, 1'b0, 32'd100, -32'sd2148, -32'sd5, 32'd2043, 32'd2);
    endtask

    task automatic test_extremes();
        run_sequence(-1, 0, 0, 1'b0, 1'b0, 32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF,
                     32'h003F_FFFF);
    endtask

    task automatic test_reset_mid_run();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (NT * NE * 14 + 2) @(posedge clk);
        #1;
        tests_run++;
        if (dp_if.step_o !== 4'd3 || dp_if.train_o !== 1'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL pre_reset_val3: step=%0d train=%0b busy=%0b, expected 3/0/1",
                     dp_if.step_o, dp_if.train_o, busy);
        end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || err !== 32'd0 || led !== 16'd0 || epoch_done !== 1'b0 ||
            dp_if.step_o !== 4'd0 || dp_if.step_valid_o !== 1'b0 || dp_if.record_o !== 13'd0 ||
            dp_if.epoch_o !== 5'd0 || dp_if.train_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset: busy=%0b done=%0b err=%h step=%0d valid=%0b rec=%0d ep=%0d, expected all zero",
                     busy, done, err, dp_if.step_o, dp_if.step_valid_o, dp_if.record_o, dp_if.epoch_o);
        end
        @(posedge clk); #1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL post_reset_idle: busy=%0b done=%0b, expected 0/0", busy, done);
        end
        run_sequence(-1, 0, 0, 1'b0, 1'b0, 32'd100, -32'sd2148, -32'sd5, 32'd2043, 32'd2);
    endtask

    task automatic test_ignored_inputs();
        run_sequence(-1, 0, 0, 1'b0, 1'b1, 32'd100, -32'sd2148, -32'sd5, 32'd2043, 32'd2);
    endtask

    initial begin
        dp_if.stall_i      = 1'b0;
        dp_if.pred_valid_i = 1'b0;
        dp_if.pred_i       = 32'd0;
        dp_if.target_i     = 32'd0;
        test_reset();
        test_small_run();
        test_stall();
        test_extremes();
        test_reset_mid_run();
        test_ignored_inputs();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
